// File: rtl/hram_arb_if.sv
// Signal bundle for hram_arb: N upstream valid/ready request ports plus the single
// downstream HRAM controller port, with grant/busy status.
interface hram_arb_if #(
    parameter int N_PORTS = 2
);
    logic [N_PORTS-1:0]    s_valid;
    logic [N_PORTS-1:0]    s_ready;
    logic [32*N_PORTS-1:0] s_addr;
    logic [32*N_PORTS-1:0] s_wdata;
    logic [4*N_PORTS-1:0]  s_wstrb;
    logic [31:0]           s_rdata;

    logic                  m_valid;
    logic                  m_ready;
    logic [31:0]           m_addr;
    logic [31:0]           m_wdata;
    logic [3:0]            m_wstrb;
    logic [31:0]           m_rdata;

    logic [2:0]            grant;
    logic                  busy;

    // Arbiter side: serves the upstream masters, drives the controller.
    modport slave (
        input  s_valid, s_addr, s_wdata, s_wstrb, m_ready, m_rdata,
        output s_ready, s_rdata, m_valid, m_addr, m_wdata, m_wstrb, grant, busy
    );

    // Environment side: upstream masters plus the HRAM controller.
    modport master (
        output s_valid, s_addr, s_wdata, s_wstrb, m_ready, m_rdata,
        input  s_ready, s_rdata, m_valid, m_addr, m_wdata, m_wstrb, grant, busy
    );
endinterface

// File: rtl/hram_arb.sv
// Round-robin arbiter sharing one HRAM PSRAM controller between N_PORTS masters.
// Define HRAM_ARB_PRIO0_EN to give port 0 absolute priority over the round-robin ports.
module hram_arb #(
    parameter int N_PORTS    = 2,
    parameter int GAP_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    hram_arb_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        RESP,
        RELEASE,
        GAP
    } state_e;

    localparam logic [2:0] LAST_PORT = 3'(N_PORTS - 1);
    localparam logic [3:0] GAP_LOAD  = 4'(GAP_CYCLES);

    state_e             state_q, state_d;
    logic [2:0]         grant_q, grant_d;
    logic [3:0]         gap_q, gap_d;
    logic [N_PORTS-1:0] s_ready_q, s_ready_d;
    logic [31:0]        s_rdata_q, s_rdata_d;
    logic               m_valid_q, m_valid_d;
    logic [31:0]        m_addr_q, m_addr_d;
    logic [31:0]        m_wdata_q, m_wdata_d;
    logic [3:0]         m_wstrb_q, m_wstrb_d;
    logic               busy_q;

`ifdef HRAM_ARB_PRIO0_EN
    localparam int RR_SPAN = (N_PORTS > 1) ? N_PORTS - 1 : 1;
    // Round-robin pointer over ports 1..N-1 only; port 0 never moves it.
    logic [2:0]         rr_q, rr_d;
`endif

    // Per-port request fields padded to 8 entries so a 3-bit index always fits.
    logic [7:0]         valid_ext;
    logic [31:0]        addr_arr  [8];
    logic [31:0]        wdata_arr [8];
    logic [3:0]         wstrb_arr [8];
    logic               win_found;
    logic [2:0]         win_idx;
    logic [2:0]         cand;

    always_comb begin
        for (int p = 0; p < 8; p++) begin
            addr_arr[p]  = '0;
            wdata_arr[p] = '0;
            wstrb_arr[p] = '0;
        end
        for (int p = 0; p < N_PORTS; p++) begin
            addr_arr[p]  = bus.s_addr[32*p +: 32];
            wdata_arr[p] = bus.s_wdata[32*p +: 32];
            wstrb_arr[p] = bus.s_wstrb[4*p +: 4];
        end
    end

    // Walk candidates from farthest to nearest so the port closest after the pointer wins.
    always_comb begin
        valid_ext = 8'(bus.s_valid);
        win_found = 1'b0;
        win_idx   = grant_q;
        cand      = '0;
`ifdef HRAM_ARB_PRIO0_EN
        for (int i = N_PORTS - 1; i >= 1; i--) begin
            cand = 3'(1 + ((int'(rr_q) - 1 + i) % RR_SPAN));
            if (valid_ext[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
        if (valid_ext[0]) begin
            win_found = 1'b1;
            win_idx   = '0;
        end
`else
        for (int i = N_PORTS; i >= 1; i--) begin
            cand = 3'((int'(grant_q) + i) % N_PORTS);
            if (valid_ext[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
`endif
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (win_found) state_d = REQ;
            REQ:     if (bus.m_ready) state_d = RESP;
            RESP:    state_d = RELEASE;
            RELEASE: if (!bus.m_ready) state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
            GAP:     if (gap_q <= 4'd1) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        grant_d   = grant_q;
        gap_d     = gap_q;
        s_ready_d = '0;
        s_rdata_d = s_rdata_q;
        m_valid_d = m_valid_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        m_wstrb_d = m_wstrb_q;
`ifdef HRAM_ARB_PRIO0_EN
        rr_d      = rr_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    grant_d   = win_idx;
                    m_valid_d = 1'b1;
                    m_addr_d  = addr_arr[win_idx];
                    m_wdata_d = wdata_arr[win_idx];
                    m_wstrb_d = wstrb_arr[win_idx];
`ifdef HRAM_ARB_PRIO0_EN
                    if (win_idx != 3'd0) rr_d = win_idx;
`endif
                end
            end
            REQ: begin
                if (bus.m_ready) begin
                    s_rdata_d = bus.m_rdata;
                    m_valid_d = 1'b0;
                    for (int p = 0; p < N_PORTS; p++) begin
                        s_ready_d[p] = (grant_q == 3'(p));
                    end
                end
            end
            RESP: ;
            RELEASE: begin
                if (!bus.m_ready) gap_d = GAP_LOAD;
            end
            GAP: begin
                gap_d = gap_q - 4'd1;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            grant_q   <= LAST_PORT;
            gap_q     <= '0;
            s_ready_q <= '0;
            s_rdata_q <= '0;
            m_valid_q <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            m_wstrb_q <= '0;
            busy_q    <= 1'b0;
`ifdef HRAM_ARB_PRIO0_EN
            rr_q      <= LAST_PORT;
`endif
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            gap_q     <= gap_d;
            s_ready_q <= s_ready_d;
            s_rdata_q <= s_rdata_d;
            m_valid_q <= m_valid_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            m_wstrb_q <= m_wstrb_d;
            busy_q    <= (state_d != IDLE);
`ifdef HRAM_ARB_PRIO0_EN
            rr_q      <= rr_d;
`endif
        end
    end

    assign bus.s_ready = s_ready_q;
    assign bus.s_rdata = s_rdata_q;
    assign bus.m_valid = m_valid_q;
    assign bus.m_addr  = m_addr_q;
    assign bus.m_wdata = m_wdata_q;
    assign bus.m_wstrb = m_wstrb_q;
    assign bus.grant   = grant_q;
    assign bus.busy    = busy_q;

endmodule
